// File: rtl/cru_pkg.sv
// Shared CRU definitions: enable-tree divider ratios and the enable-monitor state encoding.
package cru_pkg;

    localparam int unsigned DIV_FAST_240M_960K = 250;
    localparam int unsigned DIV_SLOW_960K_32K  = 30;

    typedef enum logic [1:0] {
        SEARCH,
        SYNC_FAST,
        ACQUIRE,
        LOCKED
    } monitor_state_t;

endpackage

// File: rtl/enable_period_check.sv
// Period and pulse-width checker for one clock enable, counting in units of tick_i.
// The counter loads 1 on each enable pulse and saturates at DIV+1 when a pulse goes missing.
module enable_period_check import cru_pkg::*; #(
    parameter int unsigned DIV = DIV_FAST_240M_960K,
    parameter int unsigned CW  = $clog2(DIV + 2)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic en_i,
    input  logic arm_i,
    input  logic clr_i,
    output logic period_ok_o,
    output logic period_err_o,
    output logic width_err_o
);

    localparam logic [CW-1:0] DIV_C = CW'(DIV);
    localparam logic [CW-1:0] SAT_C = CW'(DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q;

    always_comb begin
        cnt_d        = cnt_q;
        period_ok_o  = 1'b0;
        period_err_o = 1'b0;

        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = CW'(1);
        end else if (!arm_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q != SAT_C)) begin
            cnt_d = cnt_q + CW'(1);
        end

        // A pulse only counts as on-time if it lands on a tick; otherwise it is out of phase.
        if (arm_i) begin
            if (en_i) begin
                period_ok_o  = tick_i && (cnt_q == DIV_C);
                period_err_o = !(tick_i && (cnt_q == DIV_C));
            end else if (tick_i && (cnt_q == DIV_C)) begin
                period_err_o = 1'b1;
            end
        end
    end

    assign width_err_o = en_i && en_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_i;
        end
    end

endmodule

// File: rtl/cru_enable_monitor.sv
// Receiver-side monitor for the CRU clock enables en960k/en32k in the 240 MHz domain.
// Reports lock once LOCK_CNT consecutive good en32k periods are seen; keeps sticky error flags.
module cru_enable_monitor import cru_pkg::*; #(
    parameter int unsigned DIV_FAST = DIV_FAST_240M_960K,
    parameter int unsigned DIV_SLOW = DIV_SLOW_960K_32K,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERRW     = 8
) (
    input  logic            clk240m,
    input  logic            rst240m,
    input  logic            en960k,
    input  logic            en32k,
    output logic            locked,
    output logic            err_fast,
    output logic            err_slow,
    output logic            err_align,
    output logic [ERRW-1:0] err_cnt
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_C = GW'(LOCK_CNT);

    monitor_state_t  state_q, state_d;
    logic [GW-1:0]   good_q, good_d;
    logic            locked_q, locked_d;
    logic            err_fast_q, err_slow_q, err_align_q;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    logic active, slow_arm;
    logic fast_ok, fast_per_err, fast_wid_err;
    logic slow_ok, slow_per_err, slow_wid_err;
    logic v_fast, v_slow, v_align, viol;

    // Start-up is unsynchronised, so nothing counts as a violation while searching.
    assign active   = (state_q != SEARCH);
    assign slow_arm = (state_q == ACQUIRE) || (state_q == LOCKED);

    assign v_fast  = active && (fast_per_err || fast_wid_err);
    assign v_slow  = active && (slow_per_err || slow_wid_err);
    assign v_align = active && en32k && !en960k;
    assign viol    = v_fast || v_slow || v_align;

    enable_period_check #(
        .DIV (DIV_FAST)
    ) u_fast (
        .clk_i        (clk240m),
        .rst_i        (rst240m),
        .tick_i       (1'b1),
        .en_i         (en960k),
        .arm_i        (active),
        .clr_i        (viol),
        .period_ok_o  (fast_ok),
        .period_err_o (fast_per_err),
        .width_err_o  (fast_wid_err)
    );

    enable_period_check #(
        .DIV (DIV_SLOW)
    ) u_slow (
        .clk_i        (clk240m),
        .rst_i        (rst240m),
        .tick_i       (en960k),
        .en_i         (en32k),
        .arm_i        (slow_arm),
        .clr_i        (viol),
        .period_ok_o  (slow_ok),
        .period_err_o (slow_per_err),
        .width_err_o  (slow_wid_err)
    );

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        err_cnt_d = err_cnt_q;

        if (viol) begin
            state_d = SEARCH;
            good_d  = '0;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERRW'(1);
            end
        end else begin
            case (state_q)
                SEARCH: begin
                    if (en960k) begin
                        state_d = SYNC_FAST;
                    end
                end
                SYNC_FAST: begin
                    if (en32k) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end
                end
                ACQUIRE: begin
                    if (good_q == LOCK_C) begin
                        state_d = LOCKED;
                    end else if (slow_ok) begin
                        good_d = good_q + GW'(1);
                    end
                end
                LOCKED: begin
                    state_d = LOCKED;
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        locked_d = (state_q == LOCKED) && !viol;
    end

    always_ff @(posedge clk240m or posedge rst240m) begin
        if (rst240m) begin
            state_q     <= SEARCH;
            good_q      <= '0;
            locked_q    <= 1'b0;
            err_fast_q  <= 1'b0;
            err_slow_q  <= 1'b0;
            err_align_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            locked_q    <= locked_d;
            err_fast_q  <= err_fast_q  || v_fast;
            err_slow_q  <= err_slow_q  || v_slow;
            err_align_q <= err_align_q || v_align;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_fast  = err_fast_q;
    assign err_slow  = err_slow_q;
    assign err_align = err_align_q;
    assign err_cnt   = err_cnt_q;

    // Pulse-ok from the fast checker is implied by the absence of a fast violation.
    logic unused_ok;
    assign unused_ok = fast_ok;

endmodule
